// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RV32 datapath: fetch/decode/execute/memory/writeback
// with req/ready memory handshakes, sticky traps and a retired-instruction counter.
module multicycle_control_unit #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int LINK_EN     = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruction,
   input  logic             alu_zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             reg_wr,
   output logic             mem_reg,
   output logic             wb_link,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state_o
);
   // state  | meaning
   // FETCH  | request instruction, load IR on imem_ready
   // DECODE | classify opcode
   // EXEC   | R/I ALU operation
   // ADDR   | LW/SW address computation
   // MEM    | data access, SW retires here
   // WB     | register write, retire
   // BRANCH | compare and select branch target, retire
   // JUMP   | JAL target and optional link, retire
   // TRAP   | dead until reset
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ADDR   = 4'd3,
      S_MEM    = 4'd4,
      S_WB     = 4'd5,
      S_BRANCH = 4'd6,
      S_JUMP   = 4'd7,
      S_TRAP   = 4'd8
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("multicycle_control_unit: XLEN must be 32 or 64");
      end
   endgenerate

   state_t           state, state_nx;
   logic [TW-1:0]    wait_cnt;
   logic [CNT_W-1:0] instret_q;
   logic             illegal_q, bus_err_q;
   logic             waiting, timeout_hit;
   logic             unused_instr_bits;

   wire [6:0] opcode = instruction[6:0];
   wire is_r   = (opcode == OP_R);
   wire is_i   = (opcode == OP_I);
   wire is_lw  = (opcode == OP_LW);
   wire is_sw  = (opcode == OP_SW);
   wire is_beq = (opcode == OP_BEQ);
   wire is_jal = (opcode == OP_JAL);

   assign unused_instr_bits = ^instruction[31:7];

   // Counter tracks consecutive low-ready cycles; any non-waiting cycle clears it,
   // so it is always zero on entry to FETCH or MEM.
   assign waiting     = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
   assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == TW'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
         if (pc_wr)
            instret_q <= instret_q + 1'b1;
         if ((state == S_DECODE) && (state_nx == S_TRAP))
            illegal_q <= 1'b1;
         if (waiting && timeout_hit)
            bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: begin
            if (imem_ready)       state_nx = S_DECODE;
            else if (timeout_hit) state_nx = S_TRAP;
         end
         S_DECODE: begin
            if (is_r || is_i)        state_nx = S_EXEC;
            else if (is_lw || is_sw) state_nx = S_ADDR;
            else if (is_beq)         state_nx = S_BRANCH;
            else if (is_jal)         state_nx = S_JUMP;
            else                     state_nx = S_TRAP;
         end
         S_EXEC:   state_nx = S_WB;
         S_ADDR:   state_nx = S_MEM;
         S_MEM: begin
            if (dmem_ready)       state_nx = is_lw ? S_WB : S_FETCH;
            else if (timeout_hit) state_nx = S_TRAP;
         end
         S_WB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      pc_src   = 2'b00;
      alu_op   = 2'b00;
      alu_src  = 1'b0;
      reg_wr   = 1'b0;
      mem_reg  = 1'b0;
      wb_link  = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_wr    = imem_ready;
            end
            S_EXEC: begin
               alu_op  = is_r ? 2'b10 : 2'b11;
               alu_src = !is_r;
            end
            S_ADDR: alu_src = 1'b1;
            S_MEM: begin
               dmem_req = 1'b1;
               mem_rd   = is_lw;
               mem_wr   = is_sw;
               alu_src  = 1'b1;
               pc_wr    = dmem_ready && is_sw;
            end
            S_WB: begin
               reg_wr  = 1'b1;
               mem_reg = is_lw;
               pc_wr   = 1'b1;
            end
            S_BRANCH: begin
               alu_op = 2'b01;
               pc_wr  = 1'b1;
               pc_src = alu_zero ? 2'b01 : 2'b00;
            end
            S_JUMP: begin
               pc_wr   = 1'b1;
               pc_src  = 2'b10;
               reg_wr  = (LINK_EN != 0);
               wb_link = (LINK_EN != 0);
            end
            default: ;
         endcase
      end
   end

   assign instret = rst ? '0 : instret_q;
   assign illegal = !rst && illegal_q;
   assign bus_err = !rst && bus_err_q;
   assign state_o = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (default parameters and a
// short-timeout / no-link / 4-bit-counter variant) checked cycle by cycle against
// an instruction-level expected-trace model.
module tb_multicycle_control_unit;
   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic [31:0] instruction = '0;
   logic        alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        sel = 1'b0;

   logic a_imem_req, a_dmem_req, a_ir_wr, a_pc_wr, a_alu_src, a_reg_wr, a_mem_reg;
   logic a_wb_link, a_mem_rd, a_mem_wr, a_illegal, a_bus_err;
   logic [1:0]  a_pc_src, a_alu_op;
   logic [31:0] a_instret;
   logic [3:0]  a_state_o;
   logic b_imem_req, b_dmem_req, b_ir_wr, b_pc_wr, b_alu_src, b_reg_wr, b_mem_reg;
   logic b_wb_link, b_mem_rd, b_mem_wr, b_illegal, b_bus_err;
   logic [1:0]  b_pc_src, b_alu_op;
   logic [3:0]  b_instret;
   logic [3:0]  b_state_o;

   multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(16), .LINK_EN(1), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst_a), .instruction(instruction), .alu_zero(alu_zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(a_imem_req), .dmem_req(a_dmem_req), .ir_wr(a_ir_wr), .pc_wr(a_pc_wr),
      .pc_src(a_pc_src), .alu_op(a_alu_op), .alu_src(a_alu_src), .reg_wr(a_reg_wr),
      .mem_reg(a_mem_reg), .wb_link(a_wb_link), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
      .illegal(a_illegal), .bus_err(a_bus_err), .instret(a_instret), .state_o(a_state_o));

   multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(4), .LINK_EN(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .instruction(instruction), .alu_zero(alu_zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(b_imem_req), .dmem_req(b_dmem_req), .ir_wr(b_ir_wr), .pc_wr(b_pc_wr),
      .pc_src(b_pc_src), .alu_op(b_alu_op), .alu_src(b_alu_src), .reg_wr(b_reg_wr),
      .mem_reg(b_mem_reg), .wb_link(b_wb_link), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
      .illegal(b_illegal), .bus_err(b_bus_err), .instret(b_instret), .state_o(b_state_o));

   always #5 clk = ~clk;

   logic [51:0] obs_a, obs_b, obs;
   assign obs_a = {a_state_o, a_imem_req, a_dmem_req, a_ir_wr, a_pc_wr, a_pc_src, a_alu_op,
                   a_alu_src, a_reg_wr, a_mem_reg, a_wb_link, a_mem_rd, a_mem_wr,
                   a_illegal, a_bus_err, a_instret};
   assign obs_b = {b_state_o, b_imem_req, b_dmem_req, b_ir_wr, b_pc_wr, b_pc_src, b_alu_op,
                   b_alu_src, b_reg_wr, b_mem_reg, b_wb_link, b_mem_rd, b_mem_wr,
                   b_illegal, b_bus_err, 28'd0, b_instret};
   assign obs = sel ? obs_b : obs_a;

   typedef struct packed {
      logic [3:0] st;
      logic       imem_req, dmem_req, ir_wr, pc_wr;
      logic [1:0] pc_src, alu_op;
      logic       alu_src, reg_wr, mem_reg, wb_link, mem_rd, mem_wr, ill, berr;
      logic       irdy, drdy;
   } cyc_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] cnt_m [2];
   cyc_t        q[$];
   logic [6:0]  legal_ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111};

   function automatic cyc_t blank(input logic [3:0] st);
      cyc_t c;
      c      = '0;
      c.st   = st;
      c.irdy = 1'($urandom);
      c.drdy = 1'($urandom);
      return c;
   endfunction

   // Expected trace for one instruction: FETCH waits, then the per-opcode phases.
   task automatic build(input logic [31:0] ins, input int iwait, input int dwait, input logic zero);
      int         lim  = sel ? 4 : 16;
      logic       link = !sel;
      logic [6:0] op   = ins[6:0];
      cyc_t       c;
      q.delete();
      for (int k = 0; ; k++) begin
         c = blank(4'd0);
         c.imem_req = 1'b1;
         c.irdy = (k == iwait);
         c.ir_wr = c.irdy;
         q.push_back(c);
         if (c.irdy) break;
         if (k == lim) begin
            for (int t = 0; t < 6; t++) begin c = blank(4'd8); c.berr = 1'b1; q.push_back(c); end
            return;
         end
      end
      q.push_back(blank(4'd1));
      if (op == 7'b0110011 || op == 7'b0010011) begin
         c = blank(4'd2);
         c.alu_op = (op == 7'b0110011) ? 2'b10 : 2'b11;
         c.alu_src = (op == 7'b0010011);
         q.push_back(c);
         c = blank(4'd5); c.reg_wr = 1'b1; c.pc_wr = 1'b1; q.push_back(c);
      end else if (op == 7'b0000011 || op == 7'b0100011) begin
         c = blank(4'd3); c.alu_src = 1'b1; q.push_back(c);
         for (int k = 0; ; k++) begin
            c = blank(4'd4);
            c.dmem_req = 1'b1; c.alu_src = 1'b1;
            c.mem_rd = (op == 7'b0000011);
            c.mem_wr = (op == 7'b0100011);
            c.drdy = (k == dwait);
            c.pc_wr = c.drdy && c.mem_wr;
            q.push_back(c);
            if (c.drdy) break;
            if (k == lim) begin
               for (int t = 0; t < 6; t++) begin c = blank(4'd8); c.berr = 1'b1; q.push_back(c); end
               return;
            end
         end
         if (op == 7'b0000011) begin
            c = blank(4'd5); c.reg_wr = 1'b1; c.mem_reg = 1'b1; c.pc_wr = 1'b1; q.push_back(c);
         end
      end else if (op == 7'b1100011) begin
         c = blank(4'd6); c.alu_op = 2'b01; c.pc_wr = 1'b1;
         c.pc_src = zero ? 2'b01 : 2'b00;
         q.push_back(c);
      end else if (op == 7'b1101111) begin
         c = blank(4'd7); c.pc_wr = 1'b1; c.pc_src = 2'b10;
         c.reg_wr = link; c.wb_link = link;
         q.push_back(c);
      end else begin
         for (int t = 0; t < 20; t++) begin c = blank(4'd8); c.ill = 1'b1; q.push_back(c); end
      end
   endtask

   // Entered and left on a falling edge.
   task automatic run(input string name, input logic [31:0] ins, input int iwait,
                      input int dwait, input logic zero, input int limit);
      cyc_t        c;
      logic [51:0] exp;
      build(ins, iwait, dwait, zero);
      instruction = ins;
      alu_zero = zero;
      for (int k = 0; k < q.size() && k < limit; k++) begin
         c = q[k];
         imem_ready = c.irdy;
         dmem_ready = c.drdy;
         #1;
         exp = {c.st, c.imem_req, c.dmem_req, c.ir_wr, c.pc_wr, c.pc_src, c.alu_op, c.alu_src,
                c.reg_wr, c.mem_reg, c.wb_link, c.mem_rd, c.mem_wr, c.ill, c.berr, cnt_m[sel]};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", name, sel, k, obs, exp);
         end
         if (c.pc_wr) cnt_m[sel] = (cnt_m[sel] + 1) & (sel ? 32'h0000_000F : 32'hFFFF_FFFF);
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input logic s);
      sel = s;
      if (s) rst_b = 1'b1; else rst_a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
         alu_zero = 1'($urandom); instruction = $urandom;
         #1;
         total++;
         if (obs !== '0) begin
            bad++;
            $display("FAIL reset_zero dut=%0d got=%h exp=0", s, obs);
         end
         @(negedge clk);
      end
      if (s) rst_b = 1'b0; else rst_a = 1'b0;
      cnt_m[s] = '0;
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      do_reset(1'b0);
   endtask

   task automatic test_basic;
      sel = 1'b0;
      run("add", 32'h00B50533, 0, 0, 1'b0, 100);
      run("addi", 32'h00150513, 2, 0, 1'b0, 100);
      run("lw_wait", 32'h0005A503, 0, 3, 1'b0, 100);
      run("sw", 32'h00A5A023, 1, 2, 1'b0, 100);
      run("sw_zero_wait", 32'h00A5A023, 0, 0, 1'b1, 100);
   endtask

   task automatic test_beq;
      sel = 1'b0;
      run("beq_taken", 32'h00B50463, 0, 0, 1'b1, 100);
      run("beq_not_taken", 32'h00B50463, 0, 0, 1'b0, 100);
   endtask

   task automatic test_jal;
      sel = 1'b0;
      run("jal_link", 32'h008000EF, 0, 0, 1'b0, 100);
      do_reset(1'b1);
      run("jal_nolink", 32'h008000EF, 1, 0, 1'b0, 100);
   endtask

   task automatic test_illegal;
      do_reset(1'b0);
      run("illegal", 32'h0000007F, 0, 0, 1'b0, 100);
      do_reset(1'b0);
      run("after_illegal", 32'h00B50533, 0, 0, 1'b0, 100);
   endtask

   task automatic test_timeout;
      do_reset(1'b1);
      run("imem_timeout", 32'h00B50533, 5, 0, 1'b0, 100);
      do_reset(1'b1);
      run("imem_edge", 32'h00B50533, 4, 0, 1'b0, 100);
      run("dmem_edge", 32'h00A5A023, 0, 4, 1'b0, 100);
      run("dmem_timeout", 32'h0005A503, 0, 5, 1'b0, 100);
      do_reset(1'b1);
   endtask

   task automatic test_wrap;
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) run("wrap_jal", 32'h008000EF, 0, 0, 1'b0, 100);
      #1;
      total++;
      if (b_instret !== 4'd0) begin
         bad++;
         $display("FAIL instret_wrap got=%0d exp=0", b_instret);
      end
   endtask

   task automatic test_mid_reset;
      do_reset(1'b0);
      run("mid_abort", 32'h0005A503, 0, 3, 1'b0, 5);
      do_reset(1'b0);
      run("after_abort", 32'h00B50533, 0, 0, 1'b0, 100);
   endtask

   task automatic test_random;
      logic [31:0] r, ins;
      int          kind, lim;
      for (int s = 0; s < 2; s++) begin
         do_reset(1'(s));
         lim = s ? 4 : 16;
         for (int n = 0; n < 60; n++) begin
            r = $urandom;
            kind = $urandom_range(0, 6);
            if (kind == 6) ins = {r[31:7], r[0] ? 7'h7F : 7'h00};
            else           ins = {r[31:7], legal_ops[kind]};
            run("random", ins, $urandom_range(0, (s != 0) ? lim + 1 : 5),
                $urandom_range(0, (s != 0) ? lim + 1 : 5), 1'($urandom), 100);
            if (q[q.size() - 1].st == 4'd8) do_reset(1'(s));
         end
      end
   endtask

   initial begin
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_beq();
      test_jal();
      test_illegal();
      test_timeout();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
